// File: rtl/lnrv_exu_flush_ctrl_pkg.sv
// Shared definitions for the EXU flush controller.
// Defines the one-hot source bit positions of ifu_flush_src ({excp, dbg, brch})
// and the controller state type.
package lnrv_exu_flush_ctrl_pkg;

  localparam int unsigned FLUSH_SRC_W        = 3;
  localparam int unsigned FLUSH_SRC_EXCP_LOC = 2;
  localparam int unsigned FLUSH_SRC_DBG_LOC  = 1;
  localparam int unsigned FLUSH_SRC_BRCH_LOC = 0;

  typedef enum logic {
    FLUSH_IDLE  = 1'b0,
    FLUSH_ISSUE = 1'b1
  } flush_state_e;

endpackage

// File: rtl/lnrv_exu_flush_ctrl_prio_sel.sv
// Fixed-priority flush requester selector (excp > dbg > brch), purely combinational.
// Ports:
//   excp_req/dbg_req/brch_req          requests
//   *_op1/*_op2                        target operands of each requester
//   any_req                            at least one request present
//   sel_src                            one-hot winner {excp, dbg, brch}
//   sel_op1/sel_op2                    operands of the winner (zero if none)
module lnrv_flush_prio_sel
  import lnrv_exu_flush_ctrl_pkg::*;
(
  input  logic                   excp_req,
  input  logic [31:0]            excp_op1,
  input  logic [31:0]            excp_op2,
  input  logic                   dbg_req,
  input  logic [31:0]            dbg_op1,
  input  logic [31:0]            dbg_op2,
  input  logic                   brch_req,
  input  logic [31:0]            brch_op1,
  input  logic [31:0]            brch_op2,
  output logic                   any_req,
  output logic [FLUSH_SRC_W-1:0] sel_src,
  output logic [31:0]            sel_op1,
  output logic [31:0]            sel_op2
);

  always_comb begin
    sel_src = '0;
    sel_op1 = '0;
    sel_op2 = '0;
    if (excp_req) begin
      sel_src[FLUSH_SRC_EXCP_LOC] = 1'b1;
      sel_op1 = excp_op1;
      sel_op2 = excp_op2;
    end else if (dbg_req) begin
      sel_src[FLUSH_SRC_DBG_LOC] = 1'b1;
      sel_op1 = dbg_op1;
      sel_op2 = dbg_op2;
    end else if (brch_req) begin
      sel_src[FLUSH_SRC_BRCH_LOC] = 1'b1;
      sel_op1 = brch_op1;
      sel_op2 = brch_op2;
    end
  end

  assign any_req = excp_req | dbg_req | brch_req;

endmodule

// File: rtl/lnrv_exu_flush_ctrl.sv
// EXU flush controller: arbitrates trap, debug and branch flush requests,
// issues one registered redirect at a time to the IFU and counts completed flushes.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   {excp,dbg,brch}_flush_req/ack         per-source request / same-cycle acknowledge
//   {excp,dbg,brch}_flush_pc_op1/op2      per-source target operands (target = op1 + op2)
//   ifu_flush_vld/rdy                     redirect handshake toward the IFU
//   ifu_flush_pc, ifu_flush_src           registered redirect PC and one-hot owner
//   flush_cnt_clr, flush_cnt              counter clear and saturating flush count
module lnrv_exu_flush_ctrl
  import lnrv_exu_flush_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   excp_flush_req,
  output logic                   excp_flush_ack,
  input  logic [31:0]            excp_flush_pc_op1,
  input  logic [31:0]            excp_flush_pc_op2,
  input  logic                   dbg_flush_req,
  output logic                   dbg_flush_ack,
  input  logic [31:0]            dbg_flush_pc_op1,
  input  logic [31:0]            dbg_flush_pc_op2,
  input  logic                   brch_flush_req,
  output logic                   brch_flush_ack,
  input  logic [31:0]            brch_flush_pc_op1,
  input  logic [31:0]            brch_flush_pc_op2,
  output logic                   ifu_flush_vld,
  input  logic                   ifu_flush_rdy,
  output logic [31:0]            ifu_flush_pc,
  output logic [FLUSH_SRC_W-1:0] ifu_flush_src,
  input  logic                   flush_cnt_clr,
  output logic [CNT_W-1:0]       flush_cnt
);

  flush_state_e           state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [FLUSH_SRC_W-1:0] src_q, src_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   any_req;
  logic [FLUSH_SRC_W-1:0] sel_src;
  logic [31:0]            sel_op1;
  logic [31:0]            sel_op2;
  logic                   handshake;

  lnrv_flush_prio_sel u_prio_sel (
    .excp_req (excp_flush_req),
    .excp_op1 (excp_flush_pc_op1),
    .excp_op2 (excp_flush_pc_op2),
    .dbg_req  (dbg_flush_req),
    .dbg_op1  (dbg_flush_pc_op1),
    .dbg_op2  (dbg_flush_pc_op2),
    .brch_req (brch_flush_req),
    .brch_op1 (brch_flush_pc_op1),
    .brch_op2 (brch_flush_pc_op2),
    .any_req  (any_req),
    .sel_src  (sel_src),
    .sel_op1  (sel_op1),
    .sel_op2  (sel_op2)
  );

  // Reset gates the handshake so a flush pending at the reset edge is dropped
  // without ever acknowledging its owner.
  assign handshake = (state_q == FLUSH_ISSUE) && ifu_flush_rdy && !rst;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    src_d   = src_q;
    unique case (state_q)
      FLUSH_IDLE: begin
        if (any_req) begin
          state_d = FLUSH_ISSUE;
          pc_d    = sel_op1 + sel_op2;
          src_d   = sel_src;
        end
      end
      FLUSH_ISSUE: begin
        if (ifu_flush_rdy) state_d = FLUSH_IDLE;
      end
      default: state_d = FLUSH_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush_cnt_clr) begin
      cnt_d = '0;
    end else if (handshake && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FLUSH_IDLE;
      pc_q    <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ifu_flush_vld  = (state_q == FLUSH_ISSUE);
  assign ifu_flush_pc   = pc_q;
  assign ifu_flush_src  = src_q;
  assign flush_cnt      = cnt_q;
  assign excp_flush_ack = handshake && src_q[FLUSH_SRC_EXCP_LOC];
  assign dbg_flush_ack  = handshake && src_q[FLUSH_SRC_DBG_LOC];
  assign brch_flush_ack = handshake && src_q[FLUSH_SRC_BRCH_LOC];

endmodule

// File: tb/tb_lnrv_exu_flush_ctrl.sv
module tb_lnrv_exu_flush_ctrl;

  localparam int unsigned TB_CNT_W = 2;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                excp_flush_req, dbg_flush_req, brch_flush_req;
  logic                excp_flush_ack, dbg_flush_ack, brch_flush_ack;
  logic [31:0]         excp_flush_pc_op1, excp_flush_pc_op2;
  logic [31:0]         dbg_flush_pc_op1, dbg_flush_pc_op2;
  logic [31:0]         brch_flush_pc_op1, brch_flush_pc_op2;
  logic                ifu_flush_vld, ifu_flush_rdy;
  logic [31:0]         ifu_flush_pc;
  logic [2:0]          ifu_flush_src;
  logic                flush_cnt_clr;
  logic [TB_CNT_W-1:0] flush_cnt;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  lnrv_exu_flush_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .excp_flush_req    (excp_flush_req),
    .excp_flush_ack    (excp_flush_ack),
    .excp_flush_pc_op1 (excp_flush_pc_op1),
    .excp_flush_pc_op2 (excp_flush_pc_op2),
    .dbg_flush_req     (dbg_flush_req),
    .dbg_flush_ack     (dbg_flush_ack),
    .dbg_flush_pc_op1  (dbg_flush_pc_op1),
    .dbg_flush_pc_op2  (dbg_flush_pc_op2),
    .brch_flush_req    (brch_flush_req),
    .brch_flush_ack    (brch_flush_ack),
    .brch_flush_pc_op1 (brch_flush_pc_op1),
    .brch_flush_pc_op2 (brch_flush_pc_op2),
    .ifu_flush_vld     (ifu_flush_vld),
    .ifu_flush_rdy     (ifu_flush_rdy),
    .ifu_flush_pc      (ifu_flush_pc),
    .ifu_flush_src     (ifu_flush_src),
    .flush_cnt_clr     (flush_cnt_clr),
    .flush_cnt         (flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding flush with an owner index
  // (0 = excp, 1 = dbg, 2 = brch), the captured target, and a flush tally.
  bit          m_busy;
  int          m_owner;
  logic [31:0] m_pc;
  logic [2:0]  m_src;
  int          m_cnt;

  initial begin
    m_busy = 0; m_owner = 0; m_pc = '0; m_src = '0; m_cnt = 0;
  end

  always @(posedge clk) begin
    automatic bit          reqs[3];
    automatic logic [31:0] a[3];
    automatic logic [31:0] b[3];
    automatic int          c = m_cnt;
    automatic bit          found = 0;
    reqs[0] = excp_flush_req; a[0] = excp_flush_pc_op1; b[0] = excp_flush_pc_op2;
    reqs[1] = dbg_flush_req;  a[1] = dbg_flush_pc_op1;  b[1] = dbg_flush_pc_op2;
    reqs[2] = brch_flush_req; a[2] = brch_flush_pc_op1; b[2] = brch_flush_pc_op2;
    if (rst) begin
      m_busy <= 0; m_pc <= '0; m_src <= '0; m_cnt <= 0; m_owner <= 0;
    end else begin
      if (m_busy) begin
        if (ifu_flush_rdy) begin
          m_busy <= 0;
          if (c < CNT_MAX) c = c + 1;
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (reqs[i] && !found) begin
            found = 1;
            m_busy  <= 1;
            m_owner <= i;
            m_pc    <= a[i] + b[i];
            m_src   <= 3'b100 >> i;
          end
        end
      end
      if (flush_cnt_clr) c = 0;
      m_cnt <= c;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      automatic bit hs = m_busy && ifu_flush_rdy && !rst;
      chk("m_vld",   {31'b0, ifu_flush_vld},  {31'b0, m_busy});
      chk("m_pc",    ifu_flush_pc,            m_pc);
      chk("m_src",   {29'b0, ifu_flush_src},  {29'b0, m_src});
      chk("m_cnt",   {30'b0, flush_cnt},      m_cnt);
      chk("m_eack",  {31'b0, excp_flush_ack}, {31'b0, hs && m_owner == 0});
      chk("m_dack",  {31'b0, dbg_flush_ack},  {31'b0, hs && m_owner == 1});
      chk("m_back",  {31'b0, brch_flush_ack}, {31'b0, hs && m_owner == 2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; ifu_flush_rdy = 0; flush_cnt_clr = 0;
    excp_flush_req = 0; dbg_flush_req = 0; brch_flush_req = 0;
    excp_flush_pc_op1 = '0; excp_flush_pc_op2 = '0;
    dbg_flush_pc_op1 = '0;  dbg_flush_pc_op2 = '0;
    brch_flush_pc_op1 = '0; brch_flush_pc_op2 = '0;
    tick();
    started = 1;
    tick();
    rst = 0;
    at_neg();
    chk("rst_vld", {31'b0, ifu_flush_vld}, 32'd0);
    chk("rst_pc",  ifu_flush_pc, 32'd0);
    chk("rst_src", {29'b0, ifu_flush_src}, 32'd0);
    chk("rst_cnt", {30'b0, flush_cnt}, 32'd0);

    // Single branch flush with immediate IFU accept.
    brch_flush_req = 1; brch_flush_pc_op1 = 32'h8000_0100; brch_flush_pc_op2 = 32'h0000_0020;
    ifu_flush_rdy = 1;
    tick();
    at_neg();
    chk("brch_vld", {31'b0, ifu_flush_vld}, 32'd1);
    chk("brch_pc",  ifu_flush_pc, 32'h8000_0120);
    chk("brch_src", {29'b0, ifu_flush_src}, 32'b001);
    chk("brch_ack", {31'b0, brch_flush_ack}, 32'd1);
    tick();
    brch_flush_req = 0;
    at_neg();
    chk("brch_cnt", {30'b0, flush_cnt}, 32'd1);
    chk("brch_idle_vld", {31'b0, ifu_flush_vld}, 32'd0);

    // Simultaneous excp and brch: excp wins, brch follows after an idle cycle.
    flush_cnt_clr = 1;
    tick();
    flush_cnt_clr = 0;
    excp_flush_req = 1; excp_flush_pc_op1 = 32'h0000_1000; excp_flush_pc_op2 = 32'h0000_0234;
    brch_flush_req = 1; brch_flush_pc_op1 = 32'h0000_2000; brch_flush_pc_op2 = 32'h0000_0010;
    tick();
    at_neg();
    chk("pri_src",   {29'b0, ifu_flush_src}, 32'b100);
    chk("pri_pc",    ifu_flush_pc, 32'h0000_1234);
    chk("pri_eack",  {31'b0, excp_flush_ack}, 32'd1);
    chk("pri_back0", {31'b0, brch_flush_ack}, 32'd0);
    tick();
    excp_flush_req = 0;
    at_neg();
    chk("pri_gap_vld", {31'b0, ifu_flush_vld}, 32'd0);
    tick();
    at_neg();
    chk("pri2_src",  {29'b0, ifu_flush_src}, 32'b001);
    chk("pri2_pc",   ifu_flush_pc, 32'h0000_2010);
    chk("pri2_back", {31'b0, brch_flush_ack}, 32'd1);
    tick();
    brch_flush_req = 0;
    at_neg();
    chk("pri_cnt", {30'b0, flush_cnt}, 32'd2);

    // IFU stall for 5 cycles; dbg arrives mid-issue and must wait.
    brch_flush_req = 1; brch_flush_pc_op1 = 32'h0000_0400; brch_flush_pc_op2 = 32'h0000_0004;
    ifu_flush_rdy = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      at_neg();
      chk("stall_vld", {31'b0, ifu_flush_vld}, 32'd1);
      chk("stall_pc",  ifu_flush_pc, 32'h0000_0404);
      chk("stall_src", {29'b0, ifu_flush_src}, 32'b001);
      chk("stall_acks", {29'b0, excp_flush_ack, dbg_flush_ack, brch_flush_ack}, 32'd0);
      tick();
      if (i == 0) begin
        dbg_flush_req = 1; dbg_flush_pc_op1 = 32'h0000_0010; dbg_flush_pc_op2 = 32'h0000_0020;
      end
    end
    ifu_flush_rdy = 1;
    at_neg();
    chk("stall_back", {31'b0, brch_flush_ack}, 32'd1);
    chk("stall_dack0", {31'b0, dbg_flush_ack}, 32'd0);
    tick();
    brch_flush_req = 0;
    tick();
    at_neg();
    chk("dbg_src",  {29'b0, ifu_flush_src}, 32'b010);
    chk("dbg_pc",   ifu_flush_pc, 32'h0000_0030);
    chk("dbg_ack",  {31'b0, dbg_flush_ack}, 32'd1);
    tick();
    dbg_flush_req = 0;
    at_neg();
    chk("sat_cnt4", {30'b0, flush_cnt}, 32'd3);

    // Target wrap, and the counter stays saturated.
    excp_flush_req = 1; excp_flush_pc_op1 = 32'hFFFF_FFF0; excp_flush_pc_op2 = 32'h0000_0020;
    tick();
    at_neg();
    chk("wrap_pc", ifu_flush_pc, 32'h0000_0010);
    tick();
    excp_flush_req = 0;
    at_neg();
    chk("sat_cnt5", {30'b0, flush_cnt}, 32'd3);

    // Clear coincident with a handshake wins.
    brch_flush_req = 1; brch_flush_pc_op1 = 32'd1; brch_flush_pc_op2 = 32'd2;
    tick();
    flush_cnt_clr = 1;
    at_neg();
    chk("clr_back", {31'b0, brch_flush_ack}, 32'd1);
    tick();
    flush_cnt_clr = 0; brch_flush_req = 0;
    at_neg();
    chk("clr_cnt", {30'b0, flush_cnt}, 32'd0);

    // Reset while a flush is pending in ISSUE.
    excp_flush_req = 1; excp_flush_pc_op1 = 32'h10; excp_flush_pc_op2 = 32'h20;
    tick();
    tick();
    excp_flush_req = 0;
    brch_flush_req = 1; brch_flush_pc_op1 = 32'h0000_5000; brch_flush_pc_op2 = 32'h0000_0500;
    ifu_flush_rdy = 0;
    tick();
    tick();
    at_neg();
    chk("prerst_vld", {31'b0, ifu_flush_vld}, 32'd1);
    chk("prerst_cnt", {30'b0, flush_cnt}, 32'd1);
    tick();
    rst = 1; ifu_flush_rdy = 1;
    at_neg();
    chk("rstiss_back", {31'b0, brch_flush_ack}, 32'd0);
    tick();
    rst = 0; brch_flush_req = 0;
    at_neg();
    chk("rstiss_vld", {31'b0, ifu_flush_vld}, 32'd0);
    chk("rstiss_cnt", {30'b0, flush_cnt}, 32'd0);
    chk("rstiss_src", {29'b0, ifu_flush_src}, 32'd0);
    chk("rstiss_pc",  ifu_flush_pc, 32'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
